// File: rtl/pipe_frame_ctrl.sv
// rtl/pipe_frame_ctrl.sv - frame-synchronous config/geometry controller for the gray pipeline (optional watchdog: FRAME_WDOG_EN)
module pipe_frame_ctrl #(
  parameter logic [10:0] IMG_HDISP   = 11'd640,
  parameter logic [10:0] IMG_VDISP   = 11'd480,
  parameter logic [23:0] WDOG_CYCLES = 24'd2000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        per_frame_vsync,
  input  logic        per_frame_href,
  input  logic        cfg_wr,
  input  logic [7:0]  cfg_threshold,
  input  logic [3:0]  cfg_stage_en,
  input  logic        err_clr,
  output logic [7:0]  act_threshold,
  output logic [3:0]  act_stage_en,
  output logic        cfg_pending,
  output logic        cfg_applied,
  output logic        frame_active,
  output logic        frame_done,
  output logic [15:0] frame_cnt,
  output logic        err_hlen,
  output logic        err_vlen,
  output logic        err_wdog
);

  typedef enum logic [1:0] {IDLE, WAIT_START, IN_LINE, H_BLANK} state_t;

  state_t      state, next_state;
  logic        vsync_d, href_d;
  logic [10:0] pix_cnt, line_cnt, line_cnt_nxt;
  logic [7:0]  shadow_threshold;
  logic [3:0]  shadow_stage_en;

  logic vsync_rise, href_rise, href_edge;
  logic active, frame_start, frame_end, line_end;
  logic hlen_evt, vlen_evt, wdog_timeout;

  // Input history; resets high so a reset released mid-frame never looks like an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d <= 1'b1;
      href_d  <= 1'b1;
    end else begin
      vsync_d <= per_frame_vsync;
      href_d  <= per_frame_href;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state: vsync fall ends the frame ahead of any line or watchdog event
  always_comb begin
    next_state = state;
    case (state)
      IDLE:       if (!per_frame_vsync) next_state = WAIT_START;
      WAIT_START: if (vsync_rise) next_state = H_BLANK;
      H_BLANK: begin
        if (!per_frame_vsync || wdog_timeout) next_state = IDLE;
        else if (href_rise)                   next_state = IN_LINE;
      end
      IN_LINE: begin
        if (!per_frame_vsync || wdog_timeout) next_state = IDLE;
        else if (!per_frame_href)             next_state = H_BLANK;
      end
      default: next_state = IDLE;
    endcase
  end

  // Event decode feeding the registered outputs
  always_comb begin
    vsync_rise   = per_frame_vsync & ~vsync_d;
    href_rise    = per_frame_href & ~href_d;
    href_edge    = per_frame_href ^ href_d;
    active       = (state == IN_LINE) || (state == H_BLANK);
    frame_start  = (state == WAIT_START) && vsync_rise;
    frame_end    = active && !per_frame_vsync;
    line_end     = (state == IN_LINE) && (!per_frame_href || !per_frame_vsync);
    line_cnt_nxt = (line_end && line_cnt != 11'h7FF) ? line_cnt + 11'd1 : line_cnt;
    hlen_evt     = line_end && (pix_cnt != IMG_HDISP);
    vlen_evt     = frame_end && (line_cnt_nxt != IMG_VDISP);
  end

`ifdef FRAME_WDOG_EN
  logic [23:0] wdog_cnt;

  assign wdog_timeout = active && per_frame_vsync && !href_edge && (wdog_cnt == WDOG_CYCLES - 24'd1);

  // Inactivity counter restarted by every href edge and by frame start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        wdog_cnt <= 24'd0;
    else if (frame_start || href_edge) wdog_cnt <= 24'd0;
    else if (active)                   wdog_cnt <= wdog_cnt + 24'd1;
    else                               wdog_cnt <= 24'd0;
  end

  // Sticky watchdog flag; a new timeout beats a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_wdog <= 1'b0;
    else        err_wdog <= (err_wdog & ~err_clr) | wdog_timeout;
  end
`else
  logic unused_wdog;
  assign unused_wdog  = ^WDOG_CYCLES;
  assign wdog_timeout = 1'b0;
  assign err_wdog     = 1'b0;
`endif

  // Pixel and line position, both saturating at 2047
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt  <= 11'd0;
      line_cnt <= 11'd0;
    end else if (frame_start) begin
      pix_cnt  <= 11'd0;
      line_cnt <= 11'd0;
    end else begin
      line_cnt <= line_cnt_nxt;
      if (state == H_BLANK && href_rise)
        pix_cnt <= 11'd1;
      else if (state == IN_LINE && per_frame_href && pix_cnt != 11'h7FF)
        pix_cnt <= pix_cnt + 11'd1;
    end
  end

  // Shadow config, applied only at frame start; a write on that edge goes straight through
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_threshold <= 8'd40;
      shadow_stage_en  <= 4'hF;
      act_threshold    <= 8'd40;
      act_stage_en     <= 4'hF;
      cfg_pending      <= 1'b0;
      cfg_applied      <= 1'b0;
    end else begin
      cfg_applied <= 1'b0;
      if (cfg_wr) begin
        shadow_threshold <= cfg_threshold;
        shadow_stage_en  <= cfg_stage_en;
      end
      if (frame_start) begin
        cfg_pending <= 1'b0;
        if (cfg_wr) begin
          act_threshold <= cfg_threshold;
          act_stage_en  <= cfg_stage_en;
          cfg_applied   <= 1'b1;
        end else if (cfg_pending) begin
          act_threshold <= shadow_threshold;
          act_stage_en  <= shadow_stage_en;
          cfg_applied   <= 1'b1;
        end
      end else if (cfg_wr) begin
        cfg_pending <= 1'b1;
      end
    end
  end

  // Frame status: activity, completion pulse and completed-frame count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_active <= 1'b0;
      frame_done   <= 1'b0;
      frame_cnt    <= 16'd0;
    end else begin
      frame_active <= (next_state == IN_LINE) || (next_state == H_BLANK);
      frame_done   <= frame_end;
      if (frame_end) frame_cnt <= frame_cnt + 16'd1;
    end
  end

  // Sticky geometry errors; an error event beats a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_hlen <= 1'b0;
      err_vlen <= 1'b0;
    end else begin
      err_hlen <= (err_hlen & ~err_clr) | hlen_evt;
      err_vlen <= (err_vlen & ~err_clr) | vlen_evt;
    end
  end

endmodule

// File: tb/tb_pipe_frame_ctrl.sv
// tb/tb_pipe_frame_ctrl.sv - directed self-checking bench for pipe_frame_ctrl
module tb_pipe_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        per_frame_vsync;
  logic        per_frame_href;
  logic        cfg_wr;
  logic [7:0]  cfg_threshold;
  logic [3:0]  cfg_stage_en;
  logic        err_clr;
  logic [7:0]  act_threshold;
  logic [3:0]  act_stage_en;
  logic        cfg_pending;
  logic        cfg_applied;
  logic        frame_active;
  logic        frame_done;
  logic [15:0] frame_cnt;
  logic        err_hlen;
  logic        err_vlen;
  logic        err_wdog;

  int checks = 0;
  int errors = 0;
  int done_pulses = 0;
  int applied_pulses = 0;

  pipe_frame_ctrl #(
    .IMG_HDISP  (11'd8),
    .IMG_VDISP  (11'd4),
    .WDOG_CYCLES(24'd100)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .per_frame_vsync(per_frame_vsync),
    .per_frame_href (per_frame_href),
    .cfg_wr         (cfg_wr),
    .cfg_threshold  (cfg_threshold),
    .cfg_stage_en   (cfg_stage_en),
    .err_clr        (err_clr),
    .act_threshold  (act_threshold),
    .act_stage_en   (act_stage_en),
    .cfg_pending    (cfg_pending),
    .cfg_applied    (cfg_applied),
    .frame_active   (frame_active),
    .frame_done     (frame_done),
    .frame_cnt      (frame_cnt),
    .err_hlen       (err_hlen),
    .err_vlen       (err_vlen),
    .err_wdog       (err_wdog)
  );

  always #5 clk = ~clk;

  // Pulse tallies sampled on the falling edge
  always @(negedge clk) begin
    if (rst_n === 1'b1 && frame_done === 1'b1)  done_pulses++;
    if (rst_n === 1'b1 && cfg_applied === 1'b1) applied_pulses++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_line(input int n);
    per_frame_href = 1'b1;
    repeat (n) tick();
    per_frame_href = 1'b0;
    repeat (2) tick();
  endtask

  task automatic start_frame();
    per_frame_vsync = 1'b1;
    tick();
  endtask

  task automatic end_frame();
    per_frame_vsync = 1'b0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    per_frame_vsync = 1'b1;
    per_frame_href = 1'b0;
    cfg_wr = 1'b0;
    cfg_threshold = 8'd0;
    cfg_stage_en = 4'd0;
    err_clr = 1'b0;
    repeat (3) tick();

    chk("rst_thr", act_threshold, 40);
    chk("rst_en", act_stage_en, 4'hF);
    chk("rst_pend", cfg_pending, 0);
    chk("rst_appl", cfg_applied, 0);
    chk("rst_active", frame_active, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_cnt", frame_cnt, 0);
    chk("rst_hlen", err_hlen, 0);
    chk("rst_vlen", err_vlen, 0);
    chk("rst_wdog", err_wdog, 0);

    // Reset released mid-frame: frame must be ignored
    rst_n = 1'b1;
    do_line(8);
    do_line(5);
    chk("mid_active", frame_active, 0);
    chk("mid_thr", act_threshold, 40);
    chk("mid_hlen", err_hlen, 0);
    end_frame();
    tick();
    chk("mid_done_cnt", done_pulses, 0);
    chk("mid_frame_cnt", frame_cnt, 0);
    chk("mid_vlen", err_vlen, 0);

    // Frame 1: clean 4x8
    start_frame();
    chk("f1_active", frame_active, 1);
    chk("f1_appl", cfg_applied, 0);
    repeat (4) do_line(8);
    end_frame();
    chk("f1_done", frame_done, 1);
    chk("f1_cnt", frame_cnt, 1);
    chk("f1_hlen", err_hlen, 0);
    chk("f1_vlen", err_vlen, 0);
    tick();
    chk("f1_done_low", frame_done, 0);
    chk("f1_inactive", frame_active, 0);

    // Frame 2: mid-frame config write stays pending
    start_frame();
    do_line(8);
    cfg_wr = 1'b1;
    cfg_threshold = 8'd90;
    cfg_stage_en = 4'b0101;
    tick();
    cfg_wr = 1'b0;
    chk("f2_pend", cfg_pending, 1);
    chk("f2_thr_hold", act_threshold, 40);
    chk("f2_en_hold", act_stage_en, 4'hF);
    repeat (3) do_line(8);
    end_frame();
    chk("f2_cnt", frame_cnt, 2);
    chk("f2_thr_still", act_threshold, 40);
    tick();

    // Frame 3: config applied at start; short line and short frame
    start_frame();
    chk("f3_thr", act_threshold, 90);
    chk("f3_en", act_stage_en, 4'b0101);
    chk("f3_appl", cfg_applied, 1);
    chk("f3_pend", cfg_pending, 0);
    tick();
    chk("f3_appl_low", cfg_applied, 0);
    do_line(7);
    chk("f3_hlen", err_hlen, 1);
    chk("f3_vlen_pre", err_vlen, 0);
    repeat (2) do_line(8);
    end_frame();
    chk("f3_vlen", err_vlen, 1);
    chk("f3_cnt", frame_cnt, 3);
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_hlen", err_hlen, 0);
    chk("clr_vlen", err_vlen, 0);

    // Frame 4: clear coinciding with a new short-line error
    start_frame();
    per_frame_href = 1'b1;
    repeat (7) tick();
    per_frame_href = 1'b0;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    tick();
    chk("f4_hlen_wins", err_hlen, 1);
    repeat (3) do_line(8);
    end_frame();
    chk("f4_cnt", frame_cnt, 4);
    chk("f4_vlen", err_vlen, 0);
    tick();

    // Frame 5: write on the frame-start edge takes effect immediately
    per_frame_vsync = 1'b1;
    cfg_wr = 1'b1;
    cfg_threshold = 8'd200;
    cfg_stage_en = 4'b0011;
    tick();
    cfg_wr = 1'b0;
    chk("f5_thr", act_threshold, 200);
    chk("f5_en", act_stage_en, 4'b0011);
    chk("f5_pend", cfg_pending, 0);
    chk("f5_appl", cfg_applied, 1);
    repeat (4) do_line(8);
    end_frame();
    chk("f5_cnt", frame_cnt, 5);
    tick();

    // Two writes before start: last one wins
    cfg_wr = 1'b1;
    cfg_threshold = 8'd11;
    cfg_stage_en = 4'd1;
    tick();
    cfg_threshold = 8'd22;
    cfg_stage_en = 4'd2;
    tick();
    cfg_wr = 1'b0;
    chk("ow_pend", cfg_pending, 1);
    chk("ow_thr_hold", act_threshold, 200);
    start_frame();
    chk("ow_thr", act_threshold, 22);
    chk("ow_en", act_stage_en, 4'd2);
    chk("ow_appl", cfg_applied, 1);

    // Frame 6: count wraps from 0xFFFF to 0
    force dut.frame_cnt = 16'hFFFF;
    tick();
    release dut.frame_cnt;
    repeat (4) do_line(8);
    end_frame();
    chk("wrap_cnt", frame_cnt, 0);
    chk("wrap_done", frame_done, 1);
    tick();

`ifdef FRAME_WDOG_EN
    // Watchdog: vsync high with no href activity aborts the frame
    start_frame();
    repeat (99) tick();
    chk("wd_pre", err_wdog, 0);
    tick();
    chk("wd_err", err_wdog, 1);
    chk("wd_inactive", frame_active, 0);
    end_frame();
    tick();
    chk("wd_cnt", frame_cnt, 0);
`else
    chk("wdog_tied", err_wdog, 0);
`endif

    chk("done_pulses", done_pulses, 6);
    chk("applied_pulses", applied_pulses, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_frame_ctrl.md
# pipe_frame_ctrl

Frame-synchronous controller for the gray image processing chain (median, Sobel, erosion, dilation). Watches the input vsync/href stream, tracks frame, line and pixel position, and applies user configuration (Sobel threshold, per-stage enables) only at frame start so no frame is processed with mixed settings. Checks every frame's geometry against the configured resolution and reports sticky errors and frame statistics. It does not delay or modify pixel data.

## Interface
- IMG_HDISP, 11'd640, expected pixels per line
- IMG_VDISP, 11'd480, expected lines per frame
- WDOG_CYCLES, 24'd2000000, in-frame inactivity limit (used only with FRAME_WDOG_EN)
- clk  input  1  pixel clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- per_frame_vsync  input  1  frame valid, high for the whole frame
- per_frame_href  input  1  line valid, high during active pixels
- cfg_wr  input  1  one-cycle write strobe for cfg_threshold/cfg_stage_en
- cfg_threshold  input  8  requested Sobel threshold
- cfg_stage_en  input  4  requested enables {dilation, erosion, sobel, median}
- err_clr  input  1  clears all sticky error flags
- act_threshold  output  8  threshold in effect for current frame
- act_stage_en  output  4  stage enables in effect for current frame
- cfg_pending  output  1  written config waiting for next frame start
- cfg_applied  output  1  one-cycle pulse when pending config was applied
- frame_active  output  1  controller is inside a frame
- frame_done  output  1  one-cycle pulse at end of each tracked frame
- frame_cnt  output  16  completed frames, wraps 0xFFFF -> 0
- err_hlen  output  1  sticky: a line length differed from IMG_HDISP
- err_vlen  output  1  sticky: a frame line count differed from IMG_VDISP
- err_wdog  output  1  sticky: watchdog abort (constant 0 without FRAME_WDOG_EN)

## Operation
- Reset values: act_threshold 8'd40, act_stage_en 4'hF, all other outputs 0; internal vsync_d and href_d reset to 1 so a reset released mid-frame does not create a false start.
- States: IDLE (wait vsync low, armed), WAIT_START (vsync low, armed), IN_LINE (href high), H_BLANK (vsync high, href low).
- IDLE -> WAIT_START when vsync sampled 0. WAIT_START -> H_BLANK on vsync rise (vsync=1, vsync_d=0). H_BLANK -> IN_LINE on href rise. IN_LINE -> H_BLANK on href fall. H_BLANK/IN_LINE -> IDLE on vsync fall.
- Frame start (vsync rise in WAIT_START): pending config copied to act_*, cfg_pending cleared, cfg_applied pulses if pending was set; pixel and line counters cleared.
- cfg_wr: captures cfg_* into shadow, sets cfg_pending. Later write before frame start overwrites shadow. cfg_wr on the frame-start edge: the new cfg_* values go straight to act_*, cfg_pending ends 0, cfg_applied pulses.
- Pixel counter (11 bit, saturates 2047) increments each IN_LINE cycle. On href fall, or vsync fall while in IN_LINE, count != IMG_HDISP sets err_hlen; line counter (11 bit, saturates 2047) increments.
- On vsync fall: line count != IMG_VDISP sets err_vlen; frame_done pulses; frame_cnt increments.
- err_clr clears errors; an error event in the same cycle wins (flag stays 1).
- frame_active = state is H_BLANK or IN_LINE.

## Timing
- All outputs registered. act_*, cfg_applied, frame_active update on the clock edge where the vsync rise is first sampled (visible 1 cycle after the first vsync=1 input cycle).
- frame_done, frame_cnt, err_vlen update on the edge where vsync=0 is first sampled after a frame; frame_done high exactly 1 cycle.
- err_hlen updates on the edge sampling href=0 after a line.
- Frames whose start was missed (reset or watchdog mid-frame) are not counted and raise no errors; tracking resumes at the next vsync rise following vsync low.

## Configuration
- FRAME_WDOG_EN defined: 24-bit counter clears on any href edge and at frame start, increments in H_BLANK/IN_LINE; reaching WDOG_CYCLES sets err_wdog, forces IDLE, no frame_done, frame_cnt unchanged.
- Not defined: no watchdog counter, err_wdog tied 0, frame persists until vsync falls.

## Test plan
- Reset mid-frame with vsync=1 held: no cfg_applied/frame_done until vsync goes 0 then 1; outputs at reset values meanwhile.
- Parameters 8x4; clean frame of 4 lines x 8 pixels: frame_done pulses once, frame_cnt 0->1, no errors.
- cfg_wr threshold 8'd90, stage_en 4'b0101 mid-frame: act_* unchanged until next vsync rise, then 90/0101, cfg_applied 1 cycle, cfg_pending 1->0.
- One 7-pixel line and a 3-line frame: err_hlen and err_vlen set; err_clr clears both; err_clr with simultaneous new error keeps flag 1.
- cfg_wr coincident with vsync rise: new values active immediately, cfg_pending 0; frame_cnt wrap from 0xFFFF to 0 after forced preload via 65536 short frames (or hierarchical force).
- FRAME_WDOG_EN with WDOG_CYCLES=100: vsync high, href idle 100 cycles -> err_wdog 1, frame_active 0, frame_cnt unchanged.
